// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the slow-clock period meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    MEAS  = 2'd2,
    STALL = 2'd3
  } meter_state_t;

  localparam int unsigned DEF_CNT_W       = 25;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Averaging window: depth 4, divide by shifting right 2.
  localparam int unsigned AVG_DEPTH = 4;
  localparam int unsigned AVG_SHIFT = 2;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for a slow asynchronous input with registered
// single-cycle rise/fall ticks; reusable by any slow-input consumer.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_tick,
  output logic fall_tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q    <= level;
      rise_tick <= level & ~prev_q;
      fall_tick <= ~level & prev_q;
    end
  end

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow square wave in clk cycles and flags
// a stalled input. Optional PERIOD_AVG_EN adds a 4-report running average.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned     CNT_W       = DEF_CNT_W,
  parameter int unsigned     SYNC_STAGES = DEF_SYNC_STAGES,
  parameter longint unsigned TIMEOUT     = (64'd1 << CNT_W) - 64'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             en,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             stalled
`ifdef PERIOD_AVG_EN
  ,
  output logic [CNT_W-1:0] period_avg
`endif
);

  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             hph_q, hph_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             pv_d, stalled_d;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk       (clk),
    .reset     (reset),
    .async_in  (clk_in),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      hph_q        <= 1'b0;
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      hph_q        <= hph_d;
      period_out   <= period_d;
      high_out     <= high_d;
      period_valid <= pv_d;
      stalled      <= stalled_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    hph_d     = hph_q;
    period_d  = period_out;
    high_d    = high_out;
    pv_d      = 1'b0;
    stalled_d = stalled;
    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      hph_d     = 1'b0;
      stalled_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = ARM;
        end
        ARM: begin
          if (rise_tick) begin
            cnt_d   = ONE;
            hcnt_d  = ONE;
            hph_d   = 1'b1;
            state_d = MEAS;
          end
        end
        MEAS: begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (hph_q && !fall_tick && hcnt_q != CNT_MAX)
            hcnt_d = hcnt_q + 1'b1;
          if (fall_tick) begin
            high_d = hcnt_q;
            hph_d  = 1'b0;
          end
          // A rise arriving on the timeout cycle still counts as a valid period.
          if (rise_tick) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = ONE;
            hcnt_d   = ONE;
            hph_d    = 1'b1;
          end else if (cnt_q == TMO) begin
            cnt_d     = TMO;
            stalled_d = 1'b1;
            state_d   = STALL;
          end
        end
        STALL: begin
          cnt_d = TMO;
          if (rise_tick) begin
            stalled_d = 1'b0;
            cnt_d     = ONE;
            hcnt_d    = ONE;
            hph_d     = 1'b1;
            state_d   = MEAS;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PERIOD_AVG_EN
  // Holds the three previous reports; the period being reported is the fourth.
  logic [CNT_W-1:0] hist_q [AVG_DEPTH-1];
  logic [CNT_W+1:0] avg_sum;

  always_comb begin
    avg_sum = {2'b00, cnt_q};
    for (int unsigned i = 0; i < AVG_DEPTH-1; i++)
      avg_sum = avg_sum + {2'b00, hist_q[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < AVG_DEPTH-1; i++) hist_q[i] <= '0;
      period_avg <= '0;
    end else if (!en) begin
      for (int unsigned i = 0; i < AVG_DEPTH-1; i++) hist_q[i] <= '0;
    end else if (pv_d) begin
      hist_q[0] <= cnt_q;
      for (int unsigned i = 1; i < AVG_DEPTH-1; i++) hist_q[i] <= hist_q[i-1];
      period_avg <= avg_sum[AVG_SHIFT +: CNT_W];
    end
  end
`endif

endmodule
